// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the two-master memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned MASTER_TEST = 0;
  localparam int unsigned MASTER_HOST = 1;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_if.sv
// Memory-bus bundle: master-side request/response, slave-side bus and arbiter status.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MAX_PENDING = 4
) ();

  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned PEND_WIDTH = $clog2(MAX_PENDING) + 1;

  // Master side
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address;
  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable;
  logic [NUM_MASTERS-1:0]            m_read;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata;
  logic [NUM_MASTERS-1:0]            m_waitrequest;
  logic [DATA_WIDTH-1:0]             m_readdata;
  logic [NUM_MASTERS-1:0]            m_readdataready;

  // Slave side
  logic [ADDR_WIDTH-1:0]             address;
  logic [BE_WIDTH-1:0]               byteenable;
  logic                              read;
  logic                              write;
  logic [DATA_WIDTH-1:0]             writedata;
  logic                              waitrequest;
  logic [DATA_WIDTH-1:0]             readdata;
  logic                              readdataready;

  // Status
  logic                              grant;
  logic [PEND_WIDTH-1:0]             pending_count;
  logic                              orphan_err;

  // Requesting masters' view
  modport master (
    output m_address, m_byteenable, m_read, m_write, m_writedata,
    input  m_waitrequest, m_readdata, m_readdataready
  );

  // Memory (slave) view
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdataready
  );

  // Arbiter view: sits between masters and slave
  modport arb (
    input  m_address, m_byteenable, m_read, m_write, m_writedata,
    output m_waitrequest, m_readdata, m_readdataready,
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdataready,
    output grant, pending_count, orphan_err
  );

endinterface : mem_arb_if

// File: rtl/mem_arbiter_rd_tag_fifo.sv
// In-order tag FIFO remembering which master issued each outstanding read.
module rd_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        push_id,
  input  logic                        pop,
  output logic                        head_id,
  output logic                        empty,
  output logic                        full,
  output logic [ptr_width(DEPTH)-1:0] count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned IW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;

  // Occupancy and flags derived from the wrap-bit pointers
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign head_id = mem_q[rd_ptr_q[IW-1:0]];

  // Next-state for storage and pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[IW-1:0]] = push_id;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule : rd_tag_fifo

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for one SRAM port with in-order read-return steering.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic  clock,
  input  logic  reset,
  mem_arb_if.arb bus
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PW       = ptr_width(MAX_PENDING);

  logic          grant_q, grant_d;
  logic          orphan_q, orphan_d;
  logic          g, o;
  logic [1:0]    req;
  logic          rd_block;
  logic          wait_g;
  logic          accepted;
  logic          fifo_push, fifo_pop;
  logic          fifo_head, fifo_empty, fifo_full;
  logic [PW-1:0] fifo_count;

  assign g   = grant_q;
  assign o   = ~grant_q;
  assign req = bus.m_read | bus.m_write;

  // Zero-latency forwarding of the granted master's request
  assign bus.address    = g ? bus.m_address[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : bus.m_address[ADDR_WIDTH-1:0];
  assign bus.byteenable = g ? bus.m_byteenable[2*BE_WIDTH-1:BE_WIDTH]
                            : bus.m_byteenable[BE_WIDTH-1:0];
  assign bus.writedata  = g ? bus.m_writedata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : bus.m_writedata[DATA_WIDTH-1:0];

  // Reads stall once the tag FIFO is full (registered count, so no overflow)
  assign rd_block  = bus.m_read[g] & fifo_full;
  assign wait_g    = bus.waitrequest | rd_block;
  assign bus.read  = ~reset & bus.m_read[g] & ~rd_block;
  assign bus.write = ~reset & bus.m_write[g];

  // Only the granted master can see waitrequest low
  assign bus.m_waitrequest = reset ? 2'b11 : (g ? {wait_g, 1'b1} : {1'b1, wait_g});

  assign accepted  = (bus.read | bus.write) & ~wait_g;
  assign fifo_push = bus.read & ~wait_g;
  assign fifo_pop  = bus.readdataready & ~fifo_empty;

  // Read data is broadcast; the strobe goes to the master at the FIFO head
  assign bus.m_readdata      = bus.readdata;
  assign bus.m_readdataready = (reset || !fifo_pop) ? 2'b00 :
                               (fifo_head == 1'(MASTER_HOST)) ? 2'b10 : 2'b01;

  assign bus.grant         = grant_q;
  assign bus.pending_count = fifo_count;
  assign bus.orphan_err    = orphan_q;

  // Round-robin grant update and sticky orphan flag
  always_comb begin
    grant_d  = grant_q;
    orphan_d = orphan_q;
    if (req[o] && (!req[g] || accepted)) begin
      grant_d = o;
    end
    if (bus.readdataready && fifo_empty) begin
      orphan_d = 1'b1;
    end
  end

  // Grant and error registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q  <= 1'(MASTER_TEST);
      orphan_q <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      orphan_q <= orphan_d;
    end
  end

  rd_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_rd_tag_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (g),
    .pop     (fifo_pop),
    .head_id (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned MP = 4;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one clock, landing on the following negative edge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [1:0]  t4_rd   [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
  logic        t4_rdr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] t4_dat  [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333};
  logic        t4_xrd  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  t4_xrdr [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
  logic [2:0]  t4_xpnd [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    int k;
    reset                = 1'b1;
    bus.m_address        = '0;
    bus.m_byteenable     = '0;
    bus.m_read           = '0;
    bus.m_write          = '0;
    bus.m_writedata      = '0;
    bus.waitrequest      = 1'b0;
    bus.readdata         = '0;
    bus.readdataready    = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_pending", 32'(bus.pending_count), 32'd0);
    check("rst_orphan", 32'(bus.orphan_err), 32'd0);
    check("rst_mwait", 32'(bus.m_waitrequest), 32'd3);
    check("rst_read", 32'(bus.read), 32'd0);
    reset = 1'b0;

    // Master 0 alone: three back-to-back writes
    for (int i = 0; i < 3; i++) begin
      bus.m_write             = 2'b01;
      bus.m_address[AW-1:0]   = 20'h00010 + 20'(i);
      bus.m_writedata[DW-1:0] = 16'h1000 + 16'(i);
      bus.m_byteenable        = 4'b0011;
      #1;
      check("t1_write", 32'(bus.write), 32'd1);
      check("t1_addr", 32'(bus.address), 32'h10 + 32'(i));
      check("t1_wdata", 32'(bus.writedata), 32'h1000 + 32'(i));
      check("t1_be", 32'(bus.byteenable), 32'd3);
      check("t1_mwait", 32'(bus.m_waitrequest), 32'd2);
      step();
    end
    bus.m_write = 2'b00;
    #1;
    check("t1_grant", 32'(bus.grant), 32'd0);
    check("t1_idle_write", 32'(bus.write), 32'd0);
    @(negedge clock);

    // Both masters writing continuously, with one slave stall in the middle
    bus.m_write       = 2'b11;
    bus.m_address     = {20'h00200, 20'h00100};
    bus.m_writedata   = {16'h5A5A, 16'hA5A5};
    k = 0;
    for (int c = 0; c < 9; c++) begin
      bus.waitrequest = (c == 4);
      #1;
      if (c == 4) begin
        check("t2_stall_mwait", 32'(bus.m_waitrequest), 32'd3);
        check("t2_stall_write", 32'(bus.write), 32'd1);
      end else begin
        check("t2_grant", 32'(bus.grant), 32'(k % 2));
        check("t2_addr", 32'(bus.address), (k % 2 == 1) ? 32'h200 : 32'h100);
        check("t2_wdata", 32'(bus.writedata), (k % 2 == 1) ? 32'h5A5A : 32'hA5A5);
        k++;
      end
      step();
    end
    bus.waitrequest = 1'b0;
    bus.m_write     = 2'b00;
    #1;
    check("t2_end_grant", 32'(bus.grant), 32'd0);
    @(negedge clock);

    // Fill the tag FIFO from master 0, then check full-blocking and release
    bus.m_read    = 2'b01;
    bus.m_address = {20'h0, 20'h00300};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_read", 32'(bus.read), 32'd1);
      step();
      check("t3_pending", 32'(bus.pending_count), 32'(i + 1));
    end
    #1;
    check("t3_full_mwait", 32'(bus.m_waitrequest), 32'd3);
    check("t3_full_read", 32'(bus.read), 32'd0);
    check("t3_full_pending", 32'(bus.pending_count), 32'd4);
    bus.readdataready = 1'b1;
    bus.readdata      = 16'hBEEF;
    #1;
    check("t3_ret_strobe", 32'(bus.m_readdataready), 32'd1);
    check("t3_ret_data", 32'(bus.m_readdata), 32'hBEEF);
    check("t3_ret_read", 32'(bus.read), 32'd0);
    step();
    bus.readdataready = 1'b0;
    #1;
    check("t3_after_pending", 32'(bus.pending_count), 32'd3);
    check("t3_after_read", 32'(bus.read), 32'd1);
    check("t3_after_mwait", 32'(bus.m_waitrequest), 32'd2);
    step();
    check("t3_refill_pending", 32'(bus.pending_count), 32'd4);
    bus.m_read = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus.readdataready = 1'b1;
      bus.readdata      = 16'hC000 + 16'(i);
      #1;
      check("t3_drain_strobe", 32'(bus.m_readdataready), 32'd1);
      step();
    end
    bus.readdataready = 1'b0;
    check("t3_drain_pending", 32'(bus.pending_count), 32'd0);

    // Interleaved reads 0,1,0 and in-order returns
    bus.m_address = {20'h00400, 20'h00500};
    for (int c = 0; c < 8; c++) begin
      bus.m_read        = t4_rd[c];
      bus.readdataready = t4_rdr[c];
      bus.readdata      = t4_dat[c];
      #1;
      check("t4_read", 32'(bus.read), 32'(t4_xrd[c]));
      check("t4_strobe", 32'(bus.m_readdataready), 32'(t4_xrdr[c]));
      if (t4_rdr[c]) check("t4_data", 32'(bus.m_readdata), 32'(t4_dat[c]));
      step();
      check("t4_pending", 32'(bus.pending_count), 32'(t4_xpnd[c]));
    end
    bus.m_read        = 2'b00;
    bus.readdataready = 1'b0;

    // Orphan return with nothing outstanding
    bus.readdataready = 1'b1;
    bus.readdata      = 16'hDEAD;
    #1;
    check("t5_strobe", 32'(bus.m_readdataready), 32'd0);
    check("t5_orphan_pre", 32'(bus.orphan_err), 32'd0);
    step();
    bus.readdataready = 1'b0;
    check("t5_orphan", 32'(bus.orphan_err), 32'd1);
    step();
    check("t5_orphan_sticky", 32'(bus.orphan_err), 32'd1);

    // Asynchronous reset with two reads pending and grant on master 1
    bus.m_read = 2'b01;
    step();
    bus.m_read = 2'b10;
    step();
    step();
    check("t6_pre_grant", 32'(bus.grant), 32'd1);
    check("t6_pre_pending", 32'(bus.pending_count), 32'd2);
    bus.readdataready = 1'b1;
    reset             = 1'b1;
    #1;
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_pending", 32'(bus.pending_count), 32'd0);
    check("t6_orphan", 32'(bus.orphan_err), 32'd0);
    check("t6_read", 32'(bus.read), 32'd0);
    check("t6_write", 32'(bus.write), 32'd0);
    check("t6_mwait", 32'(bus.m_waitrequest), 32'd3);
    check("t6_strobe", 32'(bus.m_readdataready), 32'd0);
    step();
    reset             = 1'b0;
    bus.m_read        = 2'b00;
    bus.readdata      = 16'h5555;
    #1;
    check("t6_late_strobe", 32'(bus.m_readdataready), 32'd0);
    step();
    bus.readdataready = 1'b0;
    check("t6_late_orphan", 32'(bus.orphan_err), 32'd1);
    check("t6_late_grant", 32'(bus.grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
